// File: rtl/pcf_pkg.sv
// Shared definitions for the pulse-compression matched-filter core.
//   pcf_state_e  : control FSM state encoding (StRoot exists only with PCF_SQRT_EN)
//   acc_width()  : signed accumulator width for a given sample/tap width and length
//   mag_width()  : unsigned width of re^2 + im^2 of the accumulator
//   sat_over()   : true when a value does not fit in out_w bits
// Optional feature macro: PCF_SQRT_EN (adds the square-root stage).
package pcf_pkg;

  // Widest shifted magnitude the saturation helper accepts.
  localparam int unsigned SatMaxW = 128;

  typedef enum logic [2:0] {
    StUnloaded,
    StLoad,
    StReady,
    StMac,
    StMag,
`ifdef PCF_SQRT_EN
    StRoot,
`endif
    StOut
  } pcf_state_e;

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned cw,
                                            input int unsigned n);
    return dw + cw + 1 + $clog2(n);
  endfunction

  function automatic int unsigned mag_width(input int unsigned dw, input int unsigned cw,
                                            input int unsigned n);
    return 2 * acc_width(dw, cw, n);
  endfunction

  function automatic logic sat_over(input logic [SatMaxW-1:0] val, input int unsigned out_w);
    if (out_w >= SatMaxW) return 1'b0;
    return |(val >> out_w);
  endfunction

endpackage

// File: rtl/pcf_isqrt.sv
// Iterative non-restoring integer square root, one result bit per cycle.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : latch rad_i and begin (ignored while busy)
//   rad_i         : Width-bit unsigned radicand
//   done_o        : one-cycle pulse, root_o valid from this cycle on
//   root_o        : Width/2-bit floor(sqrt(rad_i))
// Used by pcf_stream_core only when PCF_SQRT_EN is defined.
module pcf_isqrt #(
  parameter int unsigned Width = 56
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [Width-1:0]   rad_i,
  output logic               done_o,
  output logic [Width/2-1:0] root_o
);

  localparam int unsigned HalfW = Width / 2;
  localparam int unsigned RemW  = HalfW + 2;
  localparam int unsigned CntW  = $clog2(HalfW + 1);

  logic              busy_q, done_q;
  logic [CntW-1:0]   cnt_q;
  logic [Width-1:0]  rad_q;
  logic [RemW-1:0]   rem_q, rem_sh, rem_n;
  logic [HalfW-1:0]  root_q;

  // Remainder is kept in two's complement; its sign picks subtract or add.
  always_comb begin
    rem_sh = {rem_q[RemW-3:0], rad_q[Width-1 -: 2]};
    if (!rem_q[RemW-1]) rem_n = rem_sh - {root_q, 2'b01};
    else                rem_n = rem_sh + {root_q, 2'b11};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        rad_q  <= rad_q << 2;
        rem_q  <= rem_n;
        root_q <= {root_q[HalfW-2:0], ~rem_n[RemW-1]};
        cnt_q  <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end else if (start_i) begin
        busy_q <= 1'b1;
        rad_q  <= rad_i;
        rem_q  <= '0;
        root_q <= '0;
        cnt_q  <= CntW'(HalfW - 1);
      end
    end
  end

  assign done_o = done_q;
  assign root_o = root_q;

endmodule

// File: rtl/pcf_stream_core.sv
// Streaming complex matched filter with one time-multiplexed complex MAC.
//   clock, reset_n          : clock, asynchronous active-low reset
//   coeff_valid_i/ready_o   : tap load handshake (coeff_re_i, coeff_im_i, coeff_last_i)
//   in_valid_i/in_ready_o   : sample handshake (in_re_i, in_im_i)
//   out_valid_o/out_ready_i : result handshake (out_data_o, out_sat_o)
// Output is sat((re^2+im^2) >> OUT_SHIFT); with PCF_SQRT_EN defined it is
// sat(isqrt(re^2+im^2) >> OUT_SHIFT).
module pcf_stream_core
  import pcf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned COEFF_WIDTH  = 12,
  parameter int unsigned COEFF_LENGTH = 64,
  parameter int unsigned OUT_WIDTH    = 32,
  parameter int unsigned OUT_SHIFT    = 10
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          coeff_valid_i,
  output logic                          coeff_ready_o,
  input  logic signed [COEFF_WIDTH-1:0] coeff_re_i,
  input  logic signed [COEFF_WIDTH-1:0] coeff_im_i,
  input  logic                          coeff_last_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic signed [DATA_WIDTH-1:0]  in_re_i,
  input  logic signed [DATA_WIDTH-1:0]  in_im_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [OUT_WIDTH-1:0]          out_data_o,
  output logic                          out_sat_o
);

  localparam int unsigned AccW = acc_width(DATA_WIDTH, COEFF_WIDTH, COEFF_LENGTH);
  localparam int unsigned MagW = mag_width(DATA_WIDTH, COEFF_WIDTH, COEFF_LENGTH);
  localparam int unsigned IdxW = $clog2(COEFF_LENGTH);
  localparam int unsigned CntW = $clog2(COEFF_LENGTH + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(COEFF_LENGTH - 1);
  localparam logic [IdxW-1:0] LenIdx  = IdxW'(COEFF_LENGTH);
  localparam logic [CntW-1:0] LenCnt  = CntW'(COEFF_LENGTH);

  logic signed [COEFF_WIDTH-1:0] tap_re_q [COEFF_LENGTH];
  logic signed [COEFF_WIDTH-1:0] tap_im_q [COEFF_LENGTH];
  logic signed [DATA_WIDTH-1:0]  hist_re_q [COEFF_LENGTH];
  logic signed [DATA_WIDTH-1:0]  hist_im_q [COEFF_LENGTH];

  pcf_state_e             state_q;
  logic [CntW-1:0]        tap_cnt_q, fill_q;
  logic [IdxW-1:0]        wr_ptr_q, newest_q, k_q;
  logic signed [AccW-1:0] acc_re_q, acc_im_q;
  logic                   coeff_ready_q, in_ready_q, out_valid_q, out_sat_q;
  logic [OUT_WIDTH-1:0]   out_data_q;

  logic                   coeff_hs, in_hs, tap_we, hist_we;
  logic [IdxW-1:0]        tap_widx, rd_idx, wr_ptr_nxt;
  logic signed [AccW-1:0] t_re, t_im, x_re, x_im, p_re, p_im;
  logic signed [MagW-1:0] a_re, a_im;
  logic [MagW-1:0]        mag_sq, res;
  logic [SatMaxW-1:0]     shifted;
  logic                   sat_d;
  logic [OUT_WIDTH-1:0]   data_d;

  // A pending coefficient word always beats a pending sample.
  assign coeff_hs = coeff_valid_i & coeff_ready_q;
  assign in_ready_o = in_ready_q & ~coeff_valid_i;
  assign in_hs = in_valid_i & in_ready_o;
  assign hist_we = in_hs & (state_q == StReady);
  assign wr_ptr_nxt = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + 1'b1;

  always_comb begin
    tap_we   = 1'b0;
    tap_widx = '0;
    if (coeff_hs) begin
      if (state_q == StLoad) begin
        tap_we   = tap_cnt_q < LenCnt;
        tap_widx = IdxW'(tap_cnt_q);
      end else begin
        tap_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (tap_we) begin
      tap_re_q[tap_widx] <= coeff_re_i;
      tap_im_q[tap_widx] <= coeff_im_i;
    end
    if (hist_we) begin
      hist_re_q[wr_ptr_q] <= in_re_i;
      hist_im_q[wr_ptr_q] <= in_im_i;
    end
  end

  // x[n-k] modulo the history depth; taps past the load and unfilled history read as zero.
  always_comb begin
    if (newest_q >= k_q) rd_idx = newest_q - k_q;
    else                 rd_idx = newest_q + (LenIdx - k_q);
    t_re = '0;
    t_im = '0;
    x_re = '0;
    x_im = '0;
    if (CntW'(k_q) < tap_cnt_q) begin
      t_re = AccW'(tap_re_q[k_q]);
      t_im = AccW'(tap_im_q[k_q]);
    end
    if (CntW'(k_q) < fill_q) begin
      x_re = AccW'(hist_re_q[rd_idx]);
      x_im = AccW'(hist_im_q[rd_idx]);
    end
    p_re = t_re * x_re - t_im * x_im;
    p_im = t_re * x_im + t_im * x_re;
  end

  assign a_re   = MagW'(acc_re_q);
  assign a_im   = MagW'(acc_im_q);
  assign mag_sq = $unsigned(a_re * a_re) + $unsigned(a_im * a_im);

`ifdef PCF_SQRT_EN
  logic            sq_done;
  logic [MagW/2-1:0] sq_root;

  pcf_isqrt #(
    .Width (MagW)
  ) u_isqrt (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .start_i (state_q == StMag),
    .rad_i   (mag_sq),
    .done_o  (sq_done),
    .root_o  (sq_root)
  );

  assign res = MagW'(sq_root);
`else
  logic [MagW-1:0] mag_q;
  logic            mag_ph_q;

  assign res = mag_q;
`endif

  assign shifted = SatMaxW'(res) >> OUT_SHIFT;
  assign sat_d   = sat_over(shifted, OUT_WIDTH);
  assign data_d  = sat_d ? '1 : shifted[OUT_WIDTH-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StUnloaded;
      tap_cnt_q     <= '0;
      fill_q        <= '0;
      wr_ptr_q      <= '0;
      newest_q      <= '0;
      k_q           <= '0;
      acc_re_q      <= '0;
      acc_im_q      <= '0;
      coeff_ready_q <= 1'b0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sat_q     <= 1'b0;
`ifndef PCF_SQRT_EN
      mag_q         <= '0;
      mag_ph_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StUnloaded, StReady: begin
          coeff_ready_q <= 1'b1;
          if (coeff_hs) begin
            // Tap 0 is written by this handshake; a reload also forgets the history.
            tap_cnt_q  <= CntW'(1);
            fill_q     <= '0;
            in_ready_q <= coeff_last_i;
            state_q    <= coeff_last_i ? StReady : StLoad;
          end else if (hist_we) begin
            if (fill_q < LenCnt) fill_q <= fill_q + 1'b1;
            newest_q      <= wr_ptr_q;
            wr_ptr_q      <= wr_ptr_nxt;
            k_q           <= '0;
            acc_re_q      <= '0;
            acc_im_q      <= '0;
            coeff_ready_q <= 1'b0;
            in_ready_q    <= 1'b0;
            state_q       <= StMac;
          end
        end
        StLoad: begin
          if (coeff_hs) begin
            if (tap_cnt_q < LenCnt) tap_cnt_q <= tap_cnt_q + 1'b1;
            if (coeff_last_i) begin
              in_ready_q <= 1'b1;
              state_q    <= StReady;
            end
          end
        end
        StMac: begin
          acc_re_q <= acc_re_q + p_re;
          acc_im_q <= acc_im_q + p_im;
          k_q      <= k_q + 1'b1;
          if (k_q == LastIdx) begin
`ifndef PCF_SQRT_EN
            mag_ph_q <= 1'b0;
`endif
            state_q <= StMag;
          end
        end
`ifdef PCF_SQRT_EN
        StMag: state_q <= StRoot;
        StRoot: begin
          if (sq_done) begin
            out_data_q  <= data_d;
            out_sat_q   <= sat_d;
            out_valid_q <= 1'b1;
            state_q     <= StOut;
          end
        end
`else
        // Phase 0 registers the magnitude, phase 1 shifts, saturates and presents it.
        StMag: begin
          if (!mag_ph_q) begin
            mag_q    <= mag_sq;
            mag_ph_q <= 1'b1;
          end else begin
            out_data_q  <= data_d;
            out_sat_q   <= sat_d;
            out_valid_q <= 1'b1;
            state_q     <= StOut;
          end
        end
`endif
        StOut: begin
          if (out_ready_i) begin
            out_valid_q   <= 1'b0;
            coeff_ready_q <= 1'b1;
            in_ready_q    <= 1'b1;
            state_q       <= StReady;
          end
        end
        default: state_q <= StUnloaded;
      endcase
    end
  end

  assign coeff_ready_o = coeff_ready_q;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_sat_o     = out_sat_q;

endmodule

// File: tb/tb_pcf_stream_core.sv
// Directed self-checking bench for pcf_stream_core (N=8, OUT_WIDTH=16, OUT_SHIFT=0).
// Expected values are hand-computed magnitudes squared; with PCF_SQRT_EN they are
// passed through a reference integer square root before shift and saturation.
module tb_pcf_stream_core;

  localparam int unsigned Dw = 12;
  localparam int unsigned Cw = 12;
  localparam int unsigned N  = 8;
  localparam int unsigned Ow = 16;
  localparam int unsigned Os = 0;
  localparam int unsigned MagW = 2 * (Dw + Cw + 1 + $clog2(N));
`ifdef PCF_SQRT_EN
  localparam int unsigned ExpLat = N + 2 + MagW / 2;
`else
  localparam int unsigned ExpLat = N + 2;
`endif

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 coeff_valid, coeff_ready, coeff_last;
  logic signed [Cw-1:0] coeff_re, coeff_im;
  logic                 in_valid, in_ready;
  logic signed [Dw-1:0] in_re, in_im;
  logic                 out_valid, out_ready, out_sat;
  logic [Ow-1:0]        out_data;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  logic signed [Cw-1:0] ld_re [16];
  logic signed [Cw-1:0] ld_im [16];

  always #5 clock = ~clock;

  pcf_stream_core #(
    .DATA_WIDTH   (Dw),
    .COEFF_WIDTH  (Cw),
    .COEFF_LENGTH (N),
    .OUT_WIDTH    (Ow),
    .OUT_SHIFT    (Os)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .coeff_valid_i (coeff_valid),
    .coeff_ready_o (coeff_ready),
    .coeff_re_i    (coeff_re),
    .coeff_im_i    (coeff_im),
    .coeff_last_i  (coeff_last),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_re_i       (in_re),
    .in_im_i       (in_im),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .out_sat_o     (out_sat)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

`ifdef PCF_SQRT_EN
  function automatic longint unsigned isqrt_ref(input longint unsigned v);
    longint unsigned r = 0;
    for (int b = 31; b >= 0; b--) begin
      longint unsigned t = r | (64'd1 << b);
      if (t * t <= v) r = t;
    end
    return r;
  endfunction
`endif

  function automatic longint unsigned model_r(input longint unsigned mag);
    longint unsigned r = mag;
`ifdef PCF_SQRT_EN
    r = isqrt_ref(r);
`endif
    return r >> Os;
  endfunction

  function automatic logic [63:0] model_data(input longint unsigned mag);
    longint unsigned r = model_r(mag);
    return (r > 64'd65535) ? 64'd65535 : r;
  endfunction

  function automatic logic [63:0] model_sat(input longint unsigned mag);
    return (model_r(mag) > 64'd65535) ? 64'd1 : 64'd0;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic push_coeff(input int re, input int im, input logic last);
    int t = 0;
    coeff_valid = 1'b1;
    coeff_re    = Cw'(re);
    coeff_im    = Cw'(im);
    coeff_last  = last;
    while (!coeff_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!coeff_ready) check_eq("coeff_ready_wait", coeff_ready, 1);
    @(posedge clock);
    @(negedge clock);
    coeff_valid = 1'b0;
    coeff_last  = 1'b0;
  endtask

  task automatic load_taps(input int n);
    for (int i = 0; i < n; i++) push_coeff(ld_re[i], ld_im[i], i == n - 1);
  endtask

  task automatic send_sample(input int re, input int im);
    int t = 0;
    in_valid = 1'b1;
    in_re    = Dw'(re);
    in_im    = Dw'(im);
    #1;
    while (!in_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) check_eq("in_ready_wait", in_ready, 1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
    end while (!out_valid && cyc < 300);
  endtask

  task automatic wait_result(input string tag, input longint unsigned mag, output int cyc);
    wait_valid(cyc);
    check_eq({tag, "_valid"}, out_valid, 1);
    check_eq({tag, "_data"}, out_data, model_data(mag));
    check_eq({tag, "_sat"}, out_sat, model_sat(mag));
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; coeff_valid = 1'b0; coeff_last = 1'b0; coeff_re = '0; coeff_im = '0;
    in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_sat", out_sat, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_coeff_ready", coeff_ready, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("idle_coeff_ready", coeff_ready, 1);
    check_eq("idle_in_ready", in_ready, 0);

    // Single unit tap: output is |x|^2 of the newest sample only.
    ld_re[0] = 1; ld_im[0] = 0;
    for (int i = 1; i < 4; i++) begin ld_re[i] = 0; ld_im[i] = 0; end
    load_taps(4);
    send_sample(3, 4);
    wait_result("t1_first", 25, lat);
    check_eq("t1_latency", lat, ExpLat);
    check_eq("t1_in_ready_after", in_ready, 1);
    send_sample(1, 0);
    wait_result("t1_second", 1, lat);

    // Four unit taps: output grows with history fill, then stays at 4^2.
    for (int i = 0; i < 4; i++) begin ld_re[i] = 1; ld_im[i] = 0; end
    load_taps(4);
    for (int i = 1; i <= 6; i++) begin
      send_sample(1, 0);
      wait_result("t2_fill", (i < 4 ? i : 4) ** 2, lat);
    end

    // Two-word load: stale taps 2..3 from the previous load must read as zero.
    load_taps(2);
    for (int i = 1; i <= 4; i++) begin
      send_sample(1, 0);
      wait_result("t3_short", (i < 2 ? i : 2) ** 2, lat);
    end

    // Ten-word load into 8 taps: words 8 and 9 (value 5) are dropped.
    for (int i = 0; i < 10; i++) begin ld_re[i] = (i < 8) ? 1 : 5; ld_im[i] = 0; end
    load_taps(10);
    for (int i = 1; i <= 9; i++) begin
      send_sample(1, 0);
      wait_result("t4_full", (i < 8 ? i : 8) ** 2, lat);
    end

    // Saturation and output hold under back-pressure.
    ld_re[0] = -2048; ld_im[0] = -2048;
    load_taps(1);
    out_ready = 1'b0;
    send_sample(-2048, -2048);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_eq("t5_hold_valid", out_valid, 1);
      check_eq("t5_hold_data", out_data, model_data(64'd1 << 46));
      check_eq("t5_hold_sat", out_sat, 1);
      check_eq("t5_hold_in_ready", in_ready, 0);
    end

    // Reset while a result is held: everything clears at once.
    reset_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", out_valid, 0);
    check_eq("t5_rst_data", out_data, 0);
    check_eq("t5_rst_sat", out_sat, 0);
    check_eq("t5_rst_coeff_ready", coeff_ready, 0);
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    in_valid = 1'b1; in_re = 3; in_im = 4;
    repeat (5) @(negedge clock);
    check_eq("t5_unloaded_in_ready", in_ready, 0);
    check_eq("t5_unloaded_out_valid", out_valid, 0);
    push_coeff(1, 0, 1'b1);
    send_sample(3, 4);
    wait_result("t5_reload", 25, lat);

    // Coefficient load wins over a simultaneous sample and clears history.
    ld_re[0] = 1; ld_im[0] = 0; ld_re[1] = 1; ld_im[1] = 0;
    load_taps(2);
    send_sample(1, 0);
    wait_result("t6_prime", 1, lat);
    in_valid = 1'b1; in_re = 3; in_im = 4;
    coeff_valid = 1'b1; coeff_re = 2; coeff_im = 0; coeff_last = 1'b0;
    #1;
    check_eq("t6_in_ready_forced", in_ready, 0);
    check_eq("t6_coeff_ready", coeff_ready, 1);
    push_coeff(2, 0, 1'b0);
    push_coeff(2, 0, 1'b1);
    send_sample(3, 4);
    wait_result("t6_after_reload", 100, lat);

    // Reset in the middle of a MAC: the in-flight sample never produces a result.
    send_sample(1, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_eq("t7_rst_valid", out_valid, 0);
    check_eq("t7_rst_in_ready", in_ready, 0);
    @(negedge clock);
    reset_n = 1'b1;
    in_valid = 1'b1; in_re = 1; in_im = 0;
    repeat (N + 6) @(negedge clock);
    check_eq("t7_no_result", out_valid, 0);
    check_eq("t7_in_ready_unloaded", in_ready, 0);
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
